// File: rtl/div_share_ctrl_if.sv
// ---------------------------------------------------------------------------
// div_share_ctrl_if
//   Bundles the requester-side and divider-side signals of div_share_ctrl.
//
//   Requester side : iREQ / iDIVIDEND / iDIVISOR in, oGNT / oBUSY and the
//                    tagged response (oRSP_*) out.
//   Divider side   : oDIV_DIVIDEND / oDIV_DIVISOR / oDIV_VLD / oDIV_RESET out,
//                    iDIV_QUOTIENT / iDIV_REMAINDER / iDIV_DONE in.
//
//   Handshake rules:
//   - A requester holds iREQ[k] high, with its operands stable, until it
//     sees oGNT[k]. The operands are captured on the grant edge, so they may
//     change freely afterwards.
//   - oRSP_VLD is a one-cycle strobe. The oRSP_* fields stay valid until the
//     next strobe.
//   - The divider starts on a rising edge of oDIV_VLD. It answers with a
//     one-cycle iDIV_DONE, and its result is valid in that same cycle.
//
//   Modports: slave = the controller, master = the environment that drives
//   it (requesters plus the divider).
// ---------------------------------------------------------------------------
interface div_share_ctrl_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   iREQ;
  logic [8*NREQ-1:0] iDIVIDEND;
  logic [4*NREQ-1:0] iDIVISOR;
  logic [NREQ-1:0]   oGNT;
  logic              oBUSY;
  logic              oRSP_VLD;
  logic [IDW-1:0]    oRSP_ID;
  logic [7:0]        oRSP_QUOTIENT;
  logic [3:0]        oRSP_REMAINDER;
  logic              oRSP_DIVZERO;
  logic              oRSP_TIMEOUT;
  logic [7:0]        oDIV_DIVIDEND;
  logic [3:0]        oDIV_DIVISOR;
  logic              oDIV_VLD;
  logic              oDIV_RESET;
  logic [7:0]        iDIV_QUOTIENT;
  logic [3:0]        iDIV_REMAINDER;
  logic              iDIV_DONE;

  modport slave (
    input  iREQ, iDIVIDEND, iDIVISOR, iDIV_QUOTIENT, iDIV_REMAINDER, iDIV_DONE,
    output oGNT, oBUSY, oRSP_VLD, oRSP_ID, oRSP_QUOTIENT, oRSP_REMAINDER,
           oRSP_DIVZERO, oRSP_TIMEOUT, oDIV_DIVIDEND, oDIV_DIVISOR, oDIV_VLD,
           oDIV_RESET
  );

  modport master (
    output iREQ, iDIVIDEND, iDIVISOR, iDIV_QUOTIENT, iDIV_REMAINDER, iDIV_DONE,
    input  oGNT, oBUSY, oRSP_VLD, oRSP_ID, oRSP_QUOTIENT, oRSP_REMAINDER,
           oRSP_DIVZERO, oRSP_TIMEOUT, oDIV_DIVIDEND, oDIV_DIVISOR, oDIV_VLD,
           oDIV_RESET
  );
endinterface

// File: rtl/div_share_ctrl.sv
// ---------------------------------------------------------------------------
// div_share_ctrl
//   Shares one 8-bit / 4-bit unsigned sequential divider among NREQ
//   requesters.
//   - A round-robin arbiter picks a requester and captures its operands.
//   - The controller launches the divider and waits for done.
//   - It returns the result tagged with the requester ID.
//   - A zero divisor is answered directly, without using the divider.
//   - A watchdog aborts a divider that never finishes and pulses the
//     divider reset.
//
// Ports
//   CLK        clock, rising edge
//   iRESET_N   asynchronous active-low reset
//   bus        div_share_ctrl_if.slave (requester and divider signals)
//   dbg_state  current FSM state (0 IDLE, 1 LAUNCH, 2 WAIT, 3 RESP, 4 GAP)
// ---------------------------------------------------------------------------
module div_share_ctrl #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 31
) (
  input  logic             CLK,
  input  logic             iRESET_N,
  div_share_ctrl_if.slave  bus,
  output logic [2:0]       dbg_state
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_RESP   = 3'd3,
    S_GAP    = 3'd4
  } state_t;

  state_t          state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [IDW-1:0]  ptr, ptr_d;
  logic [7:0]      cap_dividend, cap_dividend_d;
  logic [3:0]      cap_divisor, cap_divisor_d;
  logic [IDW-1:0]  cap_id, cap_id_d;
  logic [7:0]      res_q, res_q_d;
  logic [3:0]      res_r, res_r_d;
  logic            res_dz, res_dz_d;
  logic            res_to, res_to_d;
  logic [NREQ-1:0] gnt_d;
  logic [1:0]      drst_cnt;
  logic            drst_load;

  // Arbiter outputs
  logic            found;
  logic [IDW-1:0]  win;
  int              scan_idx;
  logic [7:0]      win_dividend;
  logic [3:0]      win_divisor;

  assign dbg_state         = state;
  // The divider sees the captured operands directly. They change only on a
  // grant edge, so they are already settled one cycle before oDIV_VLD rises.
  assign bus.oDIV_DIVIDEND = cap_dividend;
  assign bus.oDIV_DIVISOR  = cap_divisor;

  // Round-robin scan: the first set request at or above ptr, wrapping round.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    scan_idx = 0;
    for (int i = 0; i < NREQ; i++) begin
      scan_idx = int'(ptr) + i;
      if (scan_idx >= NREQ) scan_idx = scan_idx - NREQ;
      if (!found && bus.iREQ[scan_idx]) begin
        found = 1'b1;
        win   = IDW'(scan_idx);
      end
    end
  end

  assign win_dividend = bus.iDIVIDEND[win*8 +: 8];
  assign win_divisor  = bus.iDIVISOR[win*4 +: 4];

  // Next-state and next-register logic
  always_comb begin
    state_d        = state;
    cnt_d          = cnt;
    ptr_d          = ptr;
    cap_dividend_d = cap_dividend;
    cap_divisor_d  = cap_divisor;
    cap_id_d       = cap_id;
    res_q_d        = res_q;
    res_r_d        = res_r;
    res_dz_d       = res_dz;
    res_to_d       = res_to;
    gnt_d          = '0;
    drst_load      = 1'b0;

    unique case (state)
      S_IDLE: begin
        // Hold off while the divider is still being reset, so that a start
        // edge never overlaps an active divider reset.
        if (found && drst_cnt == 2'd0) begin
          gnt_d[win]     = 1'b1;
          cap_dividend_d = win_dividend;
          cap_divisor_d  = win_divisor;
          cap_id_d       = win;
          ptr_d          = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
          cnt_d          = '0;
          if (win_divisor == 4'd0) begin
            res_q_d  = 8'hFF;
            res_r_d  = win_dividend[3:0];
            res_dz_d = 1'b1;
            res_to_d = 1'b0;
            state_d  = S_RESP;
          end else begin
            state_d  = S_LAUNCH;
          end
        end
      end

      S_LAUNCH: begin
        if (cnt == CW'(1)) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          cnt_d   = cnt + 1'b1;
        end
      end

      S_WAIT: begin
        // Done takes priority over the watchdog on the final cycle.
        if (bus.iDIV_DONE) begin
          res_q_d  = bus.iDIV_QUOTIENT;
          res_r_d  = bus.iDIV_REMAINDER;
          res_dz_d = 1'b0;
          res_to_d = 1'b0;
          state_d  = S_RESP;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          res_q_d   = 8'h00;
          res_r_d   = 4'h0;
          res_dz_d  = 1'b0;
          res_to_d  = 1'b1;
          drst_load = 1'b1;
          state_d   = S_RESP;
        end else begin
          cnt_d     = cnt + 1'b1;
        end
      end

      S_RESP: begin
        cnt_d   = '0;
        state_d = S_GAP;
      end

      S_GAP: begin
        if (cnt == CW'(1)) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d   = cnt + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers. oDIV_VLD and oRSP_VLD follow the state one
  // cycle later, so the start edge comes after the operands have settled.
  always_ff @(posedge CLK or negedge iRESET_N) begin
    if (!iRESET_N) begin
      state              <= S_IDLE;
      cnt                <= '0;
      ptr                <= '0;
      cap_dividend       <= '0;
      cap_divisor        <= '0;
      cap_id             <= '0;
      res_q              <= '0;
      res_r              <= '0;
      res_dz             <= 1'b0;
      res_to             <= 1'b0;
      drst_cnt           <= 2'd2;
      bus.oGNT           <= '0;
      bus.oBUSY          <= 1'b0;
      bus.oRSP_VLD       <= 1'b0;
      bus.oRSP_ID        <= '0;
      bus.oRSP_QUOTIENT  <= '0;
      bus.oRSP_REMAINDER <= '0;
      bus.oRSP_DIVZERO   <= 1'b0;
      bus.oRSP_TIMEOUT   <= 1'b0;
      bus.oDIV_VLD       <= 1'b0;
      bus.oDIV_RESET     <= 1'b1;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      ptr          <= ptr_d;
      cap_dividend <= cap_dividend_d;
      cap_divisor  <= cap_divisor_d;
      cap_id       <= cap_id_d;
      res_q        <= res_q_d;
      res_r        <= res_r_d;
      res_dz       <= res_dz_d;
      res_to       <= res_to_d;
      bus.oGNT     <= gnt_d;
      bus.oBUSY    <= (state_d != S_IDLE);
      bus.oRSP_VLD <= (state == S_RESP);
      bus.oDIV_VLD <= (state == S_LAUNCH);
      if (state == S_RESP) begin
        bus.oRSP_ID        <= cap_id;
        bus.oRSP_QUOTIENT  <= res_q;
        bus.oRSP_REMAINDER <= res_r;
        bus.oRSP_DIVZERO   <= res_dz;
        bus.oRSP_TIMEOUT   <= res_to;
      end
      // The divider reset stays high for two cycles after a release or a
      // watchdog abort. The remaining count sits in drst_cnt.
      bus.oDIV_RESET <= drst_load || (drst_cnt != 2'd0);
      if (drst_load)              drst_cnt <= 2'd1;
      else if (drst_cnt != 2'd0)  drst_cnt <= drst_cnt - 2'd1;
    end
  end

endmodule
